// File: rtl/i2s_pkg.sv
// Shared types and default geometry for the I2S receive sequencer.
package i2s_pkg;

  localparam int unsigned SAMPLE_W    = 16;
  localparam int unsigned SLOT_BITS_D = 32;
  localparam int unsigned FRAME_BITS  = 2 * SLOT_BITS_D;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    STOPPING = 2'd2
  } seq_state_t;

  typedef struct packed {
    logic [SAMPLE_W-1:0] l;
    logic [SAMPLE_W-1:0] r;
  } stereo_frame_t;

endpackage

// File: rtl/i2s_frame_fifo.sv
// Synchronous stereo-frame FIFO with fall-through head; a push into a full FIFO
// is accepted only when a pop happens in the same cycle.
module i2s_frame_fifo
  import i2s_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_push,
  input  stereo_frame_t i_data,
  input  logic          i_pop,
  output stereo_frame_t o_head_c,
  output logic          o_full_c,
  output logic          o_empty_c
);

  localparam int unsigned AW = $clog2(DEPTH);

  stereo_frame_t r_mem [DEPTH];
  logic [AW:0]   r_wptr;
  logic [AW:0]   r_rptr;
  logic          w_wr;
  logic          w_rd;

  // Extra pointer MSB distinguishes full from empty.
  assign o_empty_c = (r_wptr == r_rptr);
  assign o_full_c  = (r_wptr == {~r_rptr[AW], r_rptr[AW-1:0]});
  assign o_head_c  = r_mem[r_rptr[AW-1:0]];
  assign w_rd      = i_pop && !o_empty_c;
  assign w_wr      = i_push && (!o_full_c || w_rd);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_wr) begin
        r_mem[r_wptr[AW-1:0]] <= i_data;
        r_wptr                <= r_wptr + 1'b1;
      end
      if (w_rd) begin
        r_rptr <= r_rptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/i2s_rx_sequencer.sv
// I2S receive timing master: sclk/ws generation, frame-aligned start/stop,
// stereo frame capture into a FIFO. I2S_RX_SEQ_OVR_CNT_EN adds ovr_count.
module i2s_rx_sequencer
  import i2s_pkg::*;
#(
  parameter int unsigned WIDTH      = SAMPLE_W,
  parameter int unsigned SLOT_BITS  = FRAME_BITS / 2,
  parameter int unsigned SCLK_DIV   = 24,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic             mclk,
  input  logic             rst,
  input  logic             enable,
  output logic             sclk,
  output logic             ws,
  output logic             bit_tick,
  input  logic [WIDTH-1:0] rx_data_l,
  input  logic [WIDTH-1:0] rx_data_r,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data_l,
  output logic [WIDTH-1:0] m_data_r,
  output logic             running,
  input  logic             overrun_clr,
  output logic             overrun
`ifdef I2S_RX_SEQ_OVR_CNT_EN
  ,
  output logic [7:0]       ovr_count
`endif
);

  localparam int unsigned FRAME_LEN = 2 * SLOT_BITS;
  localparam int unsigned HALF_DIV  = SCLK_DIV / 2;
  localparam int unsigned DIV_W     = $clog2(SCLK_DIV);
  localparam int unsigned BIT_W     = $clog2(FRAME_LEN);

  seq_state_t       r_state;
  logic [DIV_W-1:0] r_div_cnt;
  logic [BIT_W-1:0] r_bit_cnt;
  logic             r_sclk;
  logic             r_ws;
  logic             r_bit_tick;
  logic             r_running;
  logic             r_first;
  logic             r_cap_stb;
  logic             r_overrun;

  logic             w_active;
  logic             w_div_wrap;
  logic             w_frame_end;
  logic [DIV_W-1:0] w_div_nxt;
  logic [BIT_W-1:0] w_bit_nxt;
  stereo_frame_t    w_cap;
  stereo_frame_t    w_head;
  logic             w_full;
  logic             w_empty;
  logic             w_pop;
  logic             w_drop;

  assign w_active    = (r_state != IDLE);
  assign w_div_wrap  = w_active && (r_div_cnt == DIV_W'(SCLK_DIV - 1));
  assign w_frame_end = w_div_wrap && (r_bit_cnt == BIT_W'(FRAME_LEN - 1));
  assign w_div_nxt   = w_div_wrap ? '0 : r_div_cnt + 1'b1;
  assign w_bit_nxt   = (r_bit_cnt == BIT_W'(FRAME_LEN - 1)) ? '0 : r_bit_cnt + 1'b1;

  // Sequencer FSM with bit-clock and word-select dividers.
  always_ff @(posedge mclk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_div_cnt  <= '0;
      r_bit_cnt  <= '0;
      r_sclk     <= 1'b0;
      r_ws       <= 1'b0;
      r_bit_tick <= 1'b0;
      r_running  <= 1'b0;
      r_first    <= 1'b0;
      r_cap_stb  <= 1'b0;
    end else begin
      // The first frame after start has no preceding ws edge, so it is not captured.
      r_cap_stb <= w_frame_end && !r_first;
      if (w_frame_end) begin
        r_first <= 1'b0;
      end
      case (r_state)
        IDLE: begin
          r_div_cnt  <= '0;
          r_bit_cnt  <= '0;
          r_sclk     <= 1'b0;
          r_ws       <= 1'b0;
          r_bit_tick <= 1'b0;
          if (enable) begin
            r_state   <= RUN;
            r_running <= 1'b1;
            r_first   <= 1'b1;
          end
        end
        RUN, STOPPING: begin
          r_div_cnt  <= w_div_nxt;
          r_sclk     <= (w_div_nxt >= DIV_W'(HALF_DIV));
          r_bit_tick <= (w_div_nxt == DIV_W'(HALF_DIV - 1));
          if (w_div_wrap) begin
            r_bit_cnt <= w_bit_nxt;
            // ws leads the slot boundary by one bit.
            if (w_bit_nxt == BIT_W'(SLOT_BITS - 1)) begin
              r_ws <= 1'b1;
            end else if (w_bit_nxt == BIT_W'(FRAME_LEN - 1)) begin
              r_ws <= 1'b0;
            end
          end
          if (r_state == RUN) begin
            if (!enable) begin
              r_state <= STOPPING;
            end
          end else if (enable) begin
            r_state <= RUN;
          end else if (w_frame_end) begin
            r_state   <= IDLE;
            r_running <= 1'b0;
          end
        end
        default: begin
          r_state   <= IDLE;
          r_running <= 1'b0;
        end
      endcase
    end
  end

  assign w_cap.l = SAMPLE_W'(rx_data_l);
  assign w_cap.r = SAMPLE_W'(rx_data_r);
  assign w_pop   = m_valid && m_ready;
  assign w_drop  = r_cap_stb && w_full && !w_pop;

  i2s_frame_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (mclk),
    .rst       (rst),
    .i_push    (r_cap_stb),
    .i_data    (w_cap),
    .i_pop     (w_pop),
    .o_head_c  (w_head),
    .o_full_c  (w_full),
    .o_empty_c (w_empty)
  );

  // Sticky drop flag; a drop in the same cycle as a clear wins.
  always_ff @(posedge mclk or posedge rst) begin
    if (rst) begin
      r_overrun <= 1'b0;
    end else if (w_drop) begin
      r_overrun <= 1'b1;
    end else if (overrun_clr) begin
      r_overrun <= 1'b0;
    end
  end

`ifdef I2S_RX_SEQ_OVR_CNT_EN
  logic [7:0] r_ovr_count;

  always_ff @(posedge mclk or posedge rst) begin
    if (rst) begin
      r_ovr_count <= '0;
    end else if (overrun_clr) begin
      r_ovr_count <= {7'd0, w_drop};
    end else if (w_drop && (r_ovr_count != 8'hFF)) begin
      r_ovr_count <= r_ovr_count + 8'd1;
    end
  end

  assign ovr_count = r_ovr_count;
`endif

  assign sclk     = r_sclk;
  assign ws       = r_ws;
  assign bit_tick = r_bit_tick;
  assign running  = r_running;
  assign overrun  = r_overrun;
  assign m_valid  = !w_empty;
  assign m_data_l = WIDTH'(w_head.l);
  assign m_data_r = WIDTH'(w_head.r);

endmodule
